// File: rtl/alu_pkg.sv
// Shared ALU operation codes, FSM state encoding and op classification helpers.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD = 4'b0000,
      OP_SUB = 4'b0001,
      OP_SLL = 4'b0010,
      OP_XOR = 4'b0101,
      OP_SRL = 4'b0110,
      OP_SRA = 4'b0111,
      OP_OR  = 4'b1000,
      OP_AND = 4'b1001
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } alu_state_e;

   function automatic logic is_shift(alu_op_e op);
      return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
   endfunction

   // Raw 4-bit code check; codes outside the enum are reported as illegal.
   function automatic logic is_legal(logic [3:0] code);
      case (code)
         4'b0000, 4'b0001, 4'b0010, 4'b0101,
         4'b0110, 4'b0111, 4'b1000, 4'b1001: return 1'b1;
         default:                            return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_exec_unit_serial_shifter.sv
// Iterative 1-bit-per-cycle shifter with a down-counting shift amount.
// done pulses during the final shift cycle; data_next is the value that cycle produces.
module serial_shifter #(
   parameter  int XLEN    = 32,
   localparam int SHAMT_W = $clog2(XLEN)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               shift_en,
   input  logic               dir_left,
   input  logic               arith,
   input  logic [XLEN-1:0]    load_data,
   input  logic [SHAMT_W-1:0] load_shamt,
   output logic [XLEN-1:0]    data_next,
   output logic               done
);

   logic [XLEN-1:0]    data_q;
   logic [SHAMT_W-1:0] count_q;
   logic               left_q;
   logic               arith_q;

   // One-bit shift of the working register; SRA refills with the MSB, which never changes.
   always_comb begin
      data_next = data_q;
      if (left_q) begin
         data_next = {data_q[XLEN-2:0], 1'b0};
      end else begin
         data_next = {arith_q & data_q[XLEN-1], data_q[XLEN-1:1]};
      end
   end

   assign done = shift_en && (count_q == SHAMT_W'(1));

   // Working register, remaining count and latched shift mode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         count_q <= '0;
         left_q  <= 1'b0;
         arith_q <= 1'b0;
      end else if (load) begin
         data_q  <= load_data;
         count_q <= load_shamt;
         left_q  <= dir_left;
         arith_q <= arith;
      end else if (shift_en && (count_q != '0)) begin
         data_q  <= data_next;
         count_q <= count_q - SHAMT_W'(1);
      end
   end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: valid/ready request in, registered result/zero/illegal out.
// Single-cycle ops are computed at accept; shifts iterate in serial_shifter.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | in_ready=1, waiting for a request
// ST_SHIFT | shifter busy, one bit per cycle
// ST_DONE  | out_valid=1, result held until out_ready
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      alu_op,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            illegal
);

   localparam int SHAMT_W = $clog2(XLEN);

   alu_state_e         state_q, state_nxt;
   alu_op_e            op_e;
   logic [SHAMT_W-1:0] shamt;
   logic               accept;
   logic               shift_req;
   logic               sh_load;
   logic               sh_en;
   logic               sh_done;
   logic [XLEN-1:0]    sh_next;
   logic [XLEN-1:0]    alu_res;
   logic [XLEN-1:0]    result_q;
   logic               zero_q;
   logic               illegal_q;

   assign op_e      = alu_op_e'(alu_op);
   assign shamt     = op_b[SHAMT_W-1:0];
   assign accept    = in_valid && (state_q == ST_IDLE);
   assign shift_req = is_legal(alu_op) && is_shift(op_e) && (shamt != '0);
   assign sh_load   = accept && shift_req;
   assign sh_en     = (state_q == ST_SHIFT);

   serial_shifter #(.XLEN(XLEN)) u_shifter (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (sh_load),
      .shift_en   (sh_en),
      .dir_left   (op_e == OP_SLL),
      .arith      (op_e == OP_SRA),
      .load_data  (op_a),
      .load_shamt (shamt),
      .data_next  (sh_next),
      .done       (sh_done)
   );

   // Single-cycle datapath; a zero-amount shift passes op_a through, illegal codes give 0.
   always_comb begin
      alu_res = '0;
      case (op_e)
         OP_ADD:                 alu_res = op_a + op_b;
         OP_SUB:                 alu_res = op_a - op_b;
         OP_XOR:                 alu_res = op_a ^ op_b;
         OP_OR:                  alu_res = op_a | op_b;
         OP_AND:                 alu_res = op_a & op_b;
         OP_SLL, OP_SRL, OP_SRA: alu_res = op_a;
         default:                alu_res = '0;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         ST_IDLE:  if (accept)    state_nxt = shift_req ? ST_SHIFT : ST_DONE;
         ST_SHIFT: if (sh_done)   state_nxt = ST_DONE;
         ST_DONE:  if (out_ready) state_nxt = ST_IDLE;
         default:                 state_nxt = ST_IDLE;
      endcase
   end

   // Handshake outputs decode from state only.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         ST_IDLE: in_ready  = 1'b1;
         ST_DONE: out_valid = 1'b1;
         default: ;
      endcase
   end

   // Output registers: loaded at accept for single-cycle ops, on the last shift otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q  <= '0;
         zero_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else if (accept && !shift_req) begin
         result_q  <= alu_res;
         zero_q    <= (alu_res == '0);
         illegal_q <= !is_legal(alu_op);
      end else if (sh_done) begin
         result_q  <= sh_next;
         zero_q    <= (sh_next == '0);
         illegal_q <= 1'b0;
      end
   end

   assign result  = result_q;
   assign zero    = zero_q;
   assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expectations queued at drive time, checked at out_valid.
module tb_alu_exec_unit;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  alu_op;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;
   logic        illegal;

   typedef struct {
      logic [31:0] res;
      logic        z;
      logic        ill;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   alu_exec_unit #(.XLEN(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_op    (alu_op),
      .op_a      (op_a),
      .op_b      (op_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model_res(logic [3:0] op, logic [31:0] a, logic [31:0] b);
      logic [4:0] sh;
      sh = b[4:0];
      case (op)
         4'b0000: return a + b;
         4'b0001: return a - b;
         4'b0010: return a << sh;
         4'b0101: return a ^ b;
         4'b0110: return a >> sh;
         4'b0111: return $unsigned($signed(a) >>> sh);
         4'b1000: return a | b;
         4'b1001: return a & b;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic model_ill(logic [3:0] op);
      return !(op inside {4'b0000, 4'b0001, 4'b0010, 4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1001});
   endfunction

   function automatic int model_lat(logic [3:0] op, logic [31:0] b);
      if ((op inside {4'b0010, 4'b0110, 4'b0111}) && (b[4:0] != 5'd0)) return int'(b[4:0]) + 1;
      return 1;
   endfunction

   // Drive one request, optionally stall the result for 'stall' cycles, then consume it.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int stall);
      exp_t        e;
      exp_t        got;
      int          w;
      int          lat;
      logic [31:0] held_res;
      logic        held_z;
      logic        held_ill;
      e.res = model_res(op, a, b);
      e.ill = model_ill(op);
      e.z   = (e.res == 32'h0);
      e.lat = model_lat(op, b);
      sb.push_back(e);

      @(negedge clk);
      alu_op    = op;
      op_a      = a;
      op_b      = b;
      in_valid  = 1'b1;
      out_ready = (stall == 0);
      w = 0;
      while (!in_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);

      @(posedge clk);
      #1;
      in_valid = 1'b0;
      op_a     = $urandom;
      op_b     = $urandom;
      alu_op   = 4'($urandom);
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      got = sb.pop_front();
      chk("result",        64'(result),   64'(got.res));
      chk("zero",          64'(zero),     64'(got.z));
      chk("illegal",       64'(illegal),  64'(got.ill));
      chk("latency",       64'(lat),      64'(got.lat));
      chk("in_ready_done", 64'(in_ready), 64'd0);

      if (stall > 0) begin
         held_res = result;
         held_z   = zero;
         held_ill = illegal;
         for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            in_valid = i[0];
            alu_op   = 4'b0000;
            op_a     = $urandom;
            op_b     = $urandom;
            @(posedge clk);
            #1;
            chk("stall_result",    64'(result),    64'(held_res));
            chk("stall_zero",      64'(zero),      64'(held_z));
            chk("stall_illegal",   64'(illegal),   64'(held_ill));
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_in_ready",  64'(in_ready),  64'd0);
         end
         @(negedge clk);
         in_valid  = 1'b0;
         out_ready = 1'b1;
      end

      @(posedge clk);
      #1;
      chk("consumed_out_valid", 64'(out_valid), 64'd0);
      chk("consumed_in_ready",  64'(in_ready),  64'd1);
   endtask

   initial begin
      logic [3:0] codes [10];
      codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0101, 4'b0110,
                4'b0111, 4'b1000, 4'b1001, 4'b0011, 4'b1111};
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      alu_op    = 4'b0000;
      op_a      = 32'h0;
      op_b      = 32'h0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready",  64'(in_ready),  64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_result",    64'(result),    64'd0);
      chk("rst_zero",      64'(zero),      64'd0);
      chk("rst_illegal",   64'(illegal),   64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(OP_ADD, 32'hFFFF_FFFF, 32'h1, 0);
      run_op(OP_SUB, 32'd5, 32'd7, 0);
      run_op(OP_OR,  32'hF0, 32'h0F, 0);
      run_op(OP_AND, 32'hF0, 32'h0F, 0);
      run_op(OP_XOR, 32'hAA, 32'hFF, 0);
      run_op(OP_SRA, 32'h8000_0000, 32'd31, 0);
      run_op(OP_SRL, 32'h8000_0000, 32'd31, 0);
      run_op(OP_SLL, 32'h1, 32'h25, 0);
      run_op(OP_SRA, 32'h8000_00F0, 32'd4, 0);
      run_op(OP_SLL, 32'h1234_5678, 32'h20, 0);
      run_op(4'b0011, 32'h1234, 32'h5678, 0);
      run_op(OP_ADD, 32'h1000, 32'h0234, 0);
      run_op(OP_SUB, 32'hDEAD_BEEF, 32'h1111_1111, 10);
      run_op(OP_SRL, 32'hF000_000F, 32'd3, 4);

      for (int k = 0; k < 12; k++) begin
         run_op(codes[$urandom_range(9, 0)], $urandom, $urandom, $urandom_range(2, 0));
      end

      // Reset in the middle of a 20-bit shift.
      @(negedge clk);
      alu_op   = OP_SLL;
      op_a     = 32'h1;
      op_b     = 32'd20;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_in_ready",  64'(in_ready),  64'd1);
      chk("midrst_result",    64'(result),    64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_in_ready",  64'(in_ready),  64'd1);
      chk("post_rst_out_valid", 64'(out_valid), 64'd0);
      run_op(OP_ADD, 32'd2, 32'd3, 0);

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
